// File: rtl/frodo_pkg.sv
// Shared widths, FSM encoding and helpers for the MAC result writeback path.
package frodo_pkg;

  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_DATA_WIDTH = 64;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_FIN   = 2'd3
  } wbState_t;

  function automatic int ptrWidth(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/macs_writeback_if.sv
// Job control, result stream and RAM write port of the MAC writeback block.
interface macs_writeback_if
  import frodo_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [ADDR_WIDTH-1:0] length;
  logic [DATA_WIDTH-1:0] res_data;
  logic                  res_valid;
  logic                  res_ready;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  busy;
  logic                  done;

  modport master (
    output start, base_addr, length, res_data, res_valid,
    input  res_ready, wr_en, wr_addr, wr_data, busy, done
  );

  modport slave (
    input  start, base_addr, length, res_data, res_valid,
    output res_ready, wr_en, wr_addr, wr_data, busy, done
  );

endinterface

// File: rtl/macs_writeback_fifo.sv
// Result buffer: synchronous FIFO where a pop frees its slot on the same edge as a push.
module wb_fifo
  import frodo_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PW = ptrWidth(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wrPtr;
  logic [PW-1:0]    r_rdPtr;
  logic [CW-1:0]    r_count;
  logic             w_doPush;
  logic             w_doPop;

  assign o_full   = (r_count == CW'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign o_data   = r_mem[r_rdPtr];
  assign w_doPop  = i_pop && !o_empty;
  assign w_doPush = i_push && (!o_full || w_doPop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wrPtr] <= i_data;
  end

endmodule

// File: rtl/macs_writeback.sv
// Streams packed MAC results into RAM at consecutive (wrapping) addresses from base_addr,
// buffering accepted beats so the write port runs at one word per cycle.
module macs_writeback
  import frodo_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input logic             clk,
  input logic             rstn,
  macs_writeback_if.slave bus
);

  wbState_t              r_state;
  wbState_t              w_nextState;
  logic [ADDR_WIDTH-1:0] r_len;
  logic [ADDR_WIDTH-1:0] r_accCount;
  logic [ADDR_WIDTH-1:0] r_wrCount;
  logic [ADDR_WIDTH-1:0] r_nextAddr;
  logic [ADDR_WIDTH-1:0] r_wrAddr;
  logic [DATA_WIDTH-1:0] r_wrData;
  logic                  r_wrEn;
  logic [DATA_WIDTH-1:0] w_fifoData;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_resReady;
  logic                  w_busy;
  logic                  w_done;
  logic                  w_startJob;

  assign w_startJob = (r_state == S_IDLE) && bus.start;

  always_ff @(posedge clk) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_nextState = (bus.length == '0) ? S_FIN : S_RUN;
      S_RUN:   if (r_accCount == r_len) w_nextState = S_DRAIN;
      S_DRAIN: if (w_empty && (r_wrCount == r_len)) w_nextState = S_FIN;
      S_FIN:   w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // Status is forced low while rstn is asserted so nothing looks active during reset.
  always_comb begin
    w_resReady = 1'b0;
    w_busy     = 1'b0;
    w_done     = 1'b0;
    if (rstn) begin
      w_resReady = (r_state == S_RUN) && !w_full && (r_accCount < r_len);
      w_busy     = (r_state == S_RUN) || (r_state == S_DRAIN);
      w_done     = (r_state == S_FIN);
    end
  end

  assign w_push = bus.res_valid && w_resReady;
  assign w_pop  = w_busy && !w_empty;

  wb_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (w_push),
    .i_data  (bus.res_data),
    .i_pop   (w_pop),
    .o_data  (w_fifoData),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Job counters and the registered RAM port; the address advances once per popped word.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_len      <= '0;
      r_accCount <= '0;
      r_wrCount  <= '0;
      r_nextAddr <= '0;
      r_wrEn     <= 1'b0;
      r_wrAddr   <= '0;
      r_wrData   <= '0;
    end else begin
      if (w_startJob) begin
        r_len      <= bus.length;
        r_accCount <= '0;
        r_wrCount  <= '0;
        r_nextAddr <= bus.base_addr;
      end else begin
        if (w_push) r_accCount <= r_accCount + 1'b1;
        if (w_pop) begin
          r_wrCount  <= r_wrCount + 1'b1;
          r_nextAddr <= r_nextAddr + 1'b1;
        end
      end
      r_wrEn <= w_pop;
      if (w_pop) begin
        r_wrAddr <= r_nextAddr;
        r_wrData <= w_fifoData;
      end
    end
  end

  assign bus.res_ready = w_resReady;
  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
  assign bus.wr_en     = r_wrEn;
  assign bus.wr_addr   = r_wrAddr;
  assign bus.wr_data   = r_wrData;

endmodule

// File: tb/tb_macs_writeback.sv
// Directed and randomized jobs for macs_writeback, scored against an address/data list model.
module tb_macs_writeback;

  localparam int AW    = 12;
  localparam int DW    = 64;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rstn;
  int   checks = 0;
  int   errors = 0;

  macs_writeback_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  macs_writeback #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] words[$];
  int   jWrites, jDones, jFirstAccept, jFirstWrite, jLastWrite, jDoneCycle;
  int   jBusySeen, jReadyDrops, jExcess, jTimeout, jAborted;
  logic jStallReady;
  int   postWrites, postDones;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [AW-1:0] b, input logic [AW-1:0] l,
                               input logic v, input logic [DW-1:0] d);
    bus.start     = s;
    bus.base_addr = b;
    bus.length    = l;
    bus.res_valid = v;
    bus.res_data  = d;
  endtask

  // One job: the k-th word offered must appear as write k at (base + k) mod 2^AW.
  task automatic runJob(input logic [AW-1:0] base, input int len, input int validPct,
                        input int restartAt, input int stallAt, input int stallLen,
                        input int resetAfter);
    int            idx;
    int            cyc;
    int            doneAt;
    logic          v;
    logic [AW-1:0] expAddr;
    words.delete();
    for (int i = 0; i < len; i++) words.push_back({$urandom, $urandom});
    jWrites = 0; jDones = 0; jFirstAccept = -1; jFirstWrite = -1; jLastWrite = -1;
    jDoneCycle = -1; jBusySeen = 0; jReadyDrops = 0; jExcess = 0; jTimeout = 0;
    jAborted = 0; jStallReady = 1'b1;
    idx = 0; cyc = 0; doneAt = -1;
    @(negedge clk);
    applyStimulus(1'b1, base, AW'(len), 1'b0, '0);
    while (cyc < 300) begin
      cyc++;
      @(negedge clk);
      if (bus.wr_en === 1'b1) begin
        expAddr = base + AW'(jWrites);
        if (jWrites < len) begin
          checkOutput("wr_addr", 64'(bus.wr_addr), 64'(expAddr));
          checkOutput("wr_data", bus.wr_data, words[jWrites]);
        end else jExcess++;
        if (jFirstWrite < 0) jFirstWrite = cyc;
        jLastWrite = cyc;
        jWrites++;
      end
      if (bus.done === 1'b1) begin
        jDones++;
        jDoneCycle = cyc;
      end
      if (bus.busy === 1'b1) jBusySeen++;
      if (resetAfter >= 0 && jWrites == resetAfter) begin
        rstn = 1'b0;
        applyStimulus(1'b0, '0, '0, 1'b0, '0);
        jAborted = 1;
        break;
      end
      if (stallLen > 0 && cyc == stallAt) force dut.w_pop = 1'b0;
      if (stallLen > 0 && cyc == stallAt + stallLen) release dut.w_pop;
      v = (idx >= len) || ($urandom_range(99) < validPct);
      if (cyc == restartAt)
        applyStimulus(1'b1, 12'h100, 12'd5, v, (idx < len) ? words[idx] : 64'hDEAD);
      else
        applyStimulus(1'b0, base, AW'(len), v, (idx < len) ? words[idx] : 64'hDEAD);
      #1;
      if (stallLen > 0 && cyc == stallAt + stallLen - 1) jStallReady = bus.res_ready;
      if (bus.res_ready === 1'b1 && v) begin
        if (idx < len) begin
          if (idx == 0) jFirstAccept = cyc;
          idx++;
        end else jExcess++;
      end else if (idx > 0 && idx < len && bus.res_ready !== 1'b1) jReadyDrops++;
      if (doneAt < 0 && jDones > 0) doneAt = cyc;
      if (doneAt >= 0 && cyc >= doneAt + 2) break;
    end
    if (jDones == 0 && jAborted == 0) jTimeout = 1;
    if (jAborted == 0) applyStimulus(1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic checkJob(input string tag, input int len);
    $display("[TB] job %s: %0d writes, %0d done pulses", tag, jWrites, jDones);
    checkOutput({tag, "_write_count"}, 64'(jWrites), 64'(len));
    checkOutput({tag, "_done_count"}, 64'(jDones), 64'd1);
    checkOutput({tag, "_excess"}, 64'(jExcess), 64'd0);
    checkOutput({tag, "_timeout"}, 64'(jTimeout), 64'd0);
    if (len > 0) checkOutput({tag, "_done_after_write"}, 64'(jDoneCycle), 64'(jLastWrite + 1));
  endtask

  initial begin
    applyStimulus(1'b0, '0, '0, 1'b0, '0);
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_wr_en", 64'(bus.wr_en), 64'd0);
    checkOutput("rst_wr_addr", 64'(bus.wr_addr), 64'd0);
    checkOutput("rst_wr_data", bus.wr_data, 64'd0);
    checkOutput("rst_done", 64'(bus.done), 64'd0);
    checkOutput("rst_busy", 64'(bus.busy), 64'd0);
    checkOutput("rst_ready", 64'(bus.res_ready), 64'd0);
    rstn = 1'b1;

    runJob(12'h010, 3, 100, -1, -1, 0, -1);
    checkJob("basic", 3);
    checkOutput("basic_latency", 64'(jFirstWrite - jFirstAccept), 64'd2);
    checkOutput("basic_back_to_back", 64'(jLastWrite - jFirstWrite), 64'd2);

    runJob(12'hFFE, 4, 100, -1, -1, 0, -1);
    checkJob("wrap", 4);

    runJob(12'h123, 0, 100, -1, -1, 0, -1);
    checkJob("len0", 0);
    checkOutput("len0_done_cycle", 64'(jDoneCycle), 64'd1);
    checkOutput("len0_busy_seen", 64'(jBusySeen), 64'd0);

    runJob(12'h080, 8, 100, -1, -1, 0, -1);
    checkJob("stream", 8);
    checkOutput("stream_ready_drops", 64'(jReadyDrops), 64'd0);
    checkOutput("stream_back_to_back", 64'(jLastWrite - jFirstWrite), 64'd7);

    runJob(12'h0C0, 8, 100, -1, 2, 8, -1);
    checkJob("stall", 8);
    checkOutput("stall_ready_when_full", 64'(jStallReady), 64'd0);

    runJob(12'h040, 6, 100, 3, -1, 0, -1);
    checkJob("restart_ignored", 6);

    for (int j = 0; j < 3; j++) begin
      runJob(AW'($urandom_range(4095)), int'($urandom_range(1, 12)), 60, -1, -1, 0, -1);
      checkJob("random", words.size());
    end

    runJob(12'h300, 5, 100, -1, -1, 0, 2);
    checkOutput("abort_flag", 64'(jAborted), 64'd1);
    checkOutput("abort_no_done_before", 64'(jDones), 64'd0);
    @(negedge clk);
    checkOutput("abort_wr_en", 64'(bus.wr_en), 64'd0);
    checkOutput("abort_wr_addr", 64'(bus.wr_addr), 64'd0);
    checkOutput("abort_busy", 64'(bus.busy), 64'd0);
    checkOutput("abort_ready", 64'(bus.res_ready), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    postWrites = 0;
    postDones  = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.wr_en !== 1'b0) postWrites++;
      if (bus.done !== 1'b0) postDones++;
    end
    checkOutput("abort_post_writes", 64'(postWrites), 64'd0);
    checkOutput("abort_post_done", 64'(postDones), 64'd0);

    runJob(12'h200, 3, 100, -1, -1, 0, -1);
    checkJob("after_abort", 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
